axis_stepper: RTL and testbench

AXIS_STEPPER -- requirements
Module: axis_stepper

---
 rtl/axis_stepper_pkg.sv | 27 ++
 rtl/axis_step_chan.sv | 126 ++++++++++++
 rtl/axis_stepper.sv | 45 ++++
 tb/tb_axis_stepper.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stepper_pkg.sv
// Shared types for the axis stepper: per-axis FSM states and step directions.
package axis_stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } step_dir_e;

  // Both buttons pressed together cancel out.
  function automatic step_dir_e decode_dir(input logic inc, input logic dec);
    if (inc && !dec) return DIR_INC;
    if (dec && !inc) return DIR_DEC;
    return DIR_NONE;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_step_chan.sv
// One axis: button synchronisers, press/hold/auto-repeat FSM and the
// wrapping or clamping position register.
module axis_step_chan #(
  parameter int WIDTH        = 6,
  parameter int STEP         = 4,
  parameter int SATURATE     = 0,
  parameter int MAX_VAL      = 63,
  parameter int INIT         = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic             sysclk,
  input  logic             Reset_n,
  input  logic             clr,
  input  logic             inc_raw,
  input  logic             dec_raw,
  output logic [WIDTH-1:0] pos,
  output logic             step_pulse,
  output logic             at_min,
  output logic             at_max
);
  import axis_stepper_pkg::*;

  localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   MAX_W     = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_W    = WIDTH'(INIT);

  logic inc_meta, inc_sync, dec_meta, dec_sync;

  // NOTE: non-blocking assignments on every flop so the two synchroniser
  // stages shift together instead of collapsing into one within a cycle.
  // Clear leaves the synchroniser alone so a held button re-presses after it.
  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      inc_meta <= 1'b0;
      inc_sync <= 1'b0;
      dec_meta <= 1'b0;
      dec_sync <= 1'b0;
    end else begin
      inc_meta <= inc_raw;
      inc_sync <= inc_meta;
      dec_meta <= dec_raw;
      dec_sync <= dec_meta;
    end
  end

  step_state_e      state;
  step_dir_e        dir, latched_dir;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] step_pos;
  logic             pos_changes;

  assign dir      = decode_dir(inc_sync, dec_sync);
  assign cnt_last = (state == ST_HOLD) ? HOLD_LAST : RATE_LAST;

  // NOTE: every output of this block gets a default first, so no latch.
  // The extra top bit of sum/diff is the overflow/borrow used for clamping.
  always_comb begin
    sum      = {1'b0, pos} + STEP_W;
    diff     = {1'b0, pos} - STEP_W;
    step_pos = pos;
    case (dir)
      DIR_INC: step_pos = (SATURATE != 0 && sum > MAX_W) ? MAX_W[WIDTH-1:0] : sum[WIDTH-1:0];
      DIR_DEC: step_pos = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      default: step_pos = pos;
    endcase
    pos_changes = (step_pos != pos);
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      latched_dir <= DIR_NONE;
      cnt         <= '0;
      pos         <= INIT_W;
      step_pulse  <= 1'b0;
    end else if (clr) begin
      state       <= ST_IDLE;
      latched_dir <= DIR_NONE;
      cnt         <= '0;
      pos         <= INIT_W;
      step_pulse  <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dir != DIR_NONE) begin
            pos         <= step_pos;
            step_pulse  <= pos_changes;
            latched_dir <= dir;
            cnt         <= '0;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (dir == DIR_NONE) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (dir != latched_dir) begin
            pos         <= step_pos;
            step_pulse  <= pos_changes;
            latched_dir <= dir;
            cnt         <= '0;
            state       <= ST_HOLD;
          end else if (cnt == cnt_last) begin
            pos        <= step_pos;
            step_pulse <= pos_changes;
            cnt        <= '0;
            state      <= ST_REPEAT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign at_min = (pos == '0);
  assign at_max = (pos == MAX_W[WIDTH-1:0]);

endmodule

// File: rtl/axis_stepper.sv
// Multi-axis button stepper: one independent axis_step_chan per axis.
module axis_stepper #(
  parameter int N_AXES       = 2,
  parameter int WIDTH        = 6,
  parameter int STEP         = 4,
  parameter int SATURATE     = 0,
  parameter int MAX_VAL      = 2**WIDTH - 1,
  parameter int INIT         = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                    sysclk,
  input  logic                    Reset_n,
  input  logic                    Clr,
  input  logic [N_AXES-1:0]       Bt_Inc,
  input  logic [N_AXES-1:0]       Bt_Dec,
  output logic [N_AXES*WIDTH-1:0] Pos,
  output logic [N_AXES-1:0]       Step_Pulse,
  output logic [N_AXES-1:0]       At_Min,
  output logic [N_AXES-1:0]       At_Max
);

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    axis_step_chan #(
      .WIDTH       (WIDTH),
      .STEP        (STEP),
      .SATURATE    (SATURATE),
      .MAX_VAL     (MAX_VAL),
      .INIT        (INIT),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .sysclk    (sysclk),
      .Reset_n   (Reset_n),
      .clr       (Clr),
      .inc_raw   (Bt_Inc[i]),
      .dec_raw   (Bt_Dec[i]),
      .pos       (Pos[i*WIDTH +: WIDTH]),
      .step_pulse(Step_Pulse[i]),
      .at_min    (At_Min[i]),
      .at_max    (At_Max[i])
    );
  end

endmodule

// File: tb/tb_axis_stepper.sv
// Bench for axis_stepper: a wrapping and a clamping instance driven in
// parallel and compared against a press-age based reference model.
module tb_axis_stepper;

  localparam int NA  = 2;
  localparam int W   = 6;
  localparam int STP = 4;
  localparam int RD  = 8;
  localparam int RR  = 4;
  localparam int VW  = NA*W + 3*NA;

  logic          sysclk = 1'b0;
  logic          Reset_n, Clr;
  logic [NA-1:0] Bt_Inc, Bt_Dec;
  logic [NA*W-1:0] pos_w, pos_s;
  logic [NA-1:0] pulse_w, pulse_s, amin_w, amin_s, amax_w, amax_s;
  logic [VW-1:0] got_w, got_s;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model state, [0] = wrapping instance, [1] = clamping instance (MAX 62).
  int m_pos[2][NA];
  bit m_pulse[2][NA];
  int m_run[2][NA];   // 0 none, 1 inc, 2 dec
  int m_age[2][NA];   // edges since the press was first seen
  int max_v[2] = '{63, 62};

  typedef struct packed {
    logic [NA-1:0] inc;
    logic [NA-1:0] dec;
  } sample_t;
  sample_t hist[$];

  always #5 sysclk = ~sysclk;

  axis_stepper #(.N_AXES(NA), .WIDTH(W), .STEP(STP), .SATURATE(0),
                 .INIT(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_wrap (
    .sysclk(sysclk), .Reset_n(Reset_n), .Clr(Clr), .Bt_Inc(Bt_Inc), .Bt_Dec(Bt_Dec),
    .Pos(pos_w), .Step_Pulse(pulse_w), .At_Min(amin_w), .At_Max(amax_w));

  axis_stepper #(.N_AXES(NA), .WIDTH(W), .STEP(STP), .SATURATE(1), .MAX_VAL(62),
                 .INIT(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_sat (
    .sysclk(sysclk), .Reset_n(Reset_n), .Clr(Clr), .Bt_Inc(Bt_Inc), .Bt_Dec(Bt_Dec),
    .Pos(pos_s), .Step_Pulse(pulse_s), .At_Min(amin_s), .At_Max(amax_s));

  assign got_w = {pos_w, pulse_w, amin_w, amax_w};
  assign got_s = {pos_s, pulse_s, amin_s, amax_s};

  function automatic int step_value(int c, int p, int d);
    int n;
    n = (d == 1) ? p + STP : p - STP;
    if (c == 1) begin
      if (n > max_v[c]) n = max_v[c];
      if (n < 0) n = 0;
    end else begin
      n = (n + (1 << W)) % (1 << W);
    end
    return n;
  endfunction

  function automatic logic [VW-1:0] exp_vec(int c);
    logic [NA*W-1:0] p;
    logic [NA-1:0] pl, mn, mx;
    for (int a = 0; a < NA; a++) begin
      p[a*W +: W] = W'(m_pos[c][a]);
      pl[a] = m_pulse[c][a];
      mn[a] = (m_pos[c][a] == 0);
      mx[a] = (m_pos[c][a] == max_v[c]);
    end
    return {p, pl, mn, mx};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < NA; a++) begin
        m_pos[c][a] = 0; m_pulse[c][a] = 0; m_run[c][a] = 0; m_age[c][a] = 0;
      end
    hist.delete();
  endtask

  // A button sampled at one edge is acted on two edges later.
  task automatic model_edge();
    sample_t s;
    int d, n;
    bit fire;
    if (!Reset_n) return;
    s.inc = Bt_Inc;
    s.dec = Bt_Dec;
    hist.push_back(s);
    if (hist.size() > 3) void'(hist.pop_front());
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < NA; a++) begin
        m_pulse[c][a] = 0;
        if (Clr) begin
          m_pos[c][a] = 0; m_run[c][a] = 0; m_age[c][a] = 0;
        end else begin
          d = 0;
          if (hist.size() == 3) begin
            if (hist[0].inc[a] && !hist[0].dec[a]) d = 1;
            else if (hist[0].dec[a] && !hist[0].inc[a]) d = 2;
          end
          fire = 0;
          if (d == 0) m_run[c][a] = 0;
          else if (d != m_run[c][a]) begin
            m_run[c][a] = d; m_age[c][a] = 0; fire = 1;
          end else begin
            m_age[c][a]++;
            fire = (m_age[c][a] == RD) || (m_age[c][a] > RD && (m_age[c][a] - RD) % RR == 0);
          end
          if (fire) begin
            n = step_value(c, m_pos[c][a], d);
            m_pulse[c][a] = (n != m_pos[c][a]);
            m_pos[c][a] = n;
          end
        end
      end
  endtask

  task automatic step();
    @(posedge sysclk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic tap(input logic [NA-1:0] inc, input logic [NA-1:0] dec, output int pw, output int ps);
    pw = 0; ps = 0;
    Bt_Inc = inc; Bt_Dec = dec;
    step();
    Bt_Inc = '0; Bt_Dec = '0;
    repeat (3) begin
      step();
      pw += int'(pulse_w[0]);
      ps += int'(pulse_s[0]);
    end
  endtask

  task automatic clear_all();
    Clr = 1'b1;
    step();
    Clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*VW-1:0] got, exp;
    Reset_n = 1'b1; Clr = 1'b0; Bt_Inc = '0; Bt_Dec = '0;
    #2 Reset_n = 1'b0;
    #1 model_reset();
    got = {pos_w, pos_s, pulse_w, pulse_s, amin_w, amin_s, amax_w, amax_s};
    exp = {{2*NA*W{1'b0}}, {2*NA{1'b0}}, {2*NA{1'b1}}, {2*NA{1'b0}}};
    if (got === exp) n_pass++;
    else $display("FAIL reset_state got=%h exp=%h", got, exp);
    n_total++;
    repeat (3) step();
    Reset_n = 1'b1;
    step();
    if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
    else $display("FAIL reset_release got=%h/%h exp=%h/%h", got_w, got_s, exp_vec(0), exp_vec(1));
    n_total++;
  endtask

  task automatic test_tap();
    Bt_Inc[0] = 1'b1;
    step();
    Bt_Inc[0] = 1'b0;
    step();
    step();
    if (pos_w[W-1:0] === 6'd4 && pulse_w[0] === 1'b1 && pos_s[W-1:0] === 6'd4) n_pass++;
    else $display("FAIL tap_edge3 pos_w=%0d pulse=%b pos_s=%0d exp=4/1/4", pos_w[W-1:0], pulse_w[0], pos_s[W-1:0]);
    n_total++;
    repeat (6) begin
      step();
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL tap_settle cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
  endtask

  task automatic test_hold();
    int npulse = 0;
    Bt_Inc[0] = 1'b1;
    repeat (24) begin
      step();
      npulse += int'(pulse_w[0]);
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL hold cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
    if (npulse == 5) n_pass++;
    else $display("FAIL hold_pulse_count got=%0d exp=5", npulse);
    n_total++;
    Bt_Inc[0] = 1'b0;
    repeat (8) begin
      step();
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL hold_release cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
  endtask

  task automatic test_wrap();
    int pw, ps;
    clear_all();
    tap(2'b00, 2'b01, pw, ps);
    if (pos_w[W-1:0] === 6'd60 && pw == 1 && pos_s[W-1:0] === 6'd0 && ps == 0 && amin_s[0] === 1'b1) n_pass++;
    else $display("FAIL wrap_dec pos_w=%0d pw=%0d pos_s=%0d ps=%0d exp=60/1/0/0", pos_w[W-1:0], pw, pos_s[W-1:0], ps);
    n_total++;
    tap(2'b01, 2'b00, pw, ps);
    if (pos_w[W-1:0] === 6'd0 && pw == 1 && amin_w[0] === 1'b1 && pos_s[W-1:0] === 6'd4) n_pass++;
    else $display("FAIL wrap_inc pos_w=%0d pw=%0d pos_s=%0d exp=0/1/4", pos_w[W-1:0], pw, pos_s[W-1:0]);
    n_total++;
  endtask

  task automatic test_clamp();
    int pw, ps;
    clear_all();
    repeat (15) tap(2'b01, 2'b00, pw, ps);
    if (pos_s[W-1:0] === 6'd60 && pos_w[W-1:0] === 6'd60) n_pass++;
    else $display("FAIL clamp_setup pos_s=%0d pos_w=%0d exp=60/60", pos_s[W-1:0], pos_w[W-1:0]);
    n_total++;
    tap(2'b01, 2'b00, pw, ps);
    if (pos_s[W-1:0] === 6'd62 && amax_s[0] === 1'b1 && ps == 1 && pos_w[W-1:0] === 6'd0) n_pass++;
    else $display("FAIL clamp_to_max pos_s=%0d at_max=%b ps=%0d pos_w=%0d exp=62/1/1/0", pos_s[W-1:0], amax_s[0], ps, pos_w[W-1:0]);
    n_total++;
    tap(2'b01, 2'b00, pw, ps);
    if (pos_s[W-1:0] === 6'd62 && ps == 0 && pw == 1) n_pass++;
    else $display("FAIL clamp_noop pos_s=%0d ps=%0d pw=%0d exp=62/0/1", pos_s[W-1:0], ps, pw);
    n_total++;
    repeat (15) tap(2'b00, 2'b01, pw, ps);
    if (pos_s[W-1:0] === 6'd2) n_pass++;
    else $display("FAIL clamp_down pos_s=%0d exp=2", pos_s[W-1:0]);
    n_total++;
    tap(2'b00, 2'b01, pw, ps);
    if (pos_s[W-1:0] === 6'd0 && amin_s[0] === 1'b1 && ps == 1) n_pass++;
    else $display("FAIL clamp_to_min pos_s=%0d at_min=%b ps=%0d exp=0/1/1", pos_s[W-1:0], amin_s[0], ps);
    n_total++;
    if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
    else $display("FAIL clamp_model got=%h/%h exp=%h/%h", got_w, got_s, exp_vec(0), exp_vec(1));
    n_total++;
  endtask

  task automatic test_conflict();
    int npulse = 0;
    clear_all();
    Bt_Inc[1] = 1'b1; Bt_Dec[1] = 1'b1;
    repeat (20) begin
      step();
      npulse += int'(pulse_w[1]) + int'(pulse_s[1]);
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL conflict cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
    if (pos_w[2*W-1:W] === 6'd0 && pos_s[2*W-1:W] === 6'd0 && npulse == 0) n_pass++;
    else $display("FAIL conflict_still pos_w=%0d pos_s=%0d pulses=%0d exp=0/0/0", pos_w[2*W-1:W], pos_s[2*W-1:W], npulse);
    n_total++;
    Bt_Inc = '0; Bt_Dec = '0;
    repeat (3) step();
  endtask

  task automatic test_clr_priority();
    Bt_Inc[0] = 1'b1; Bt_Dec[1] = 1'b1;
    repeat (20) begin
      step();
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL clr_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
    clear_all();
    if (pos_w === '0 && pos_s === '0 && pulse_w === '0 && pulse_s === '0) n_pass++;
    else $display("FAIL clr_apply pos_w=%h pos_s=%h pulses=%b/%b exp=0", pos_w, pos_s, pulse_w, pulse_s);
    n_total++;
    step();
    if (pos_w === {6'd60, 6'd4} && pos_s === {6'd0, 6'd4} && pulse_w === 2'b11 && pulse_s === 2'b01) n_pass++;
    else $display("FAIL clr_repress pos_w=%h pos_s=%h pulses=%b/%b exp=f04/004/11/01", pos_w, pos_s, pulse_w, pulse_s);
    n_total++;
    repeat (10) begin
      step();
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL clr_after cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
    Bt_Inc = '0; Bt_Dec = '0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid_repeat();
    Bt_Inc[0] = 1'b1; Bt_Dec[1] = 1'b1;
    repeat (20) begin
      step();
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL rst_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
    #3 Reset_n = 1'b0;
    #1 model_reset();
    if (pos_w === '0 && pos_s === '0 && pulse_w === '0 && pulse_s === '0) n_pass++;
    else $display("FAIL rst_async pos_w=%h pos_s=%h pulses=%b/%b exp=0", pos_w, pos_s, pulse_w, pulse_s);
    n_total++;
    repeat (2) step();
    Reset_n = 1'b1;
    step();
    step();
    if (pos_w === '0 && pos_s === '0) n_pass++;
    else $display("FAIL rst_latency pos_w=%h pos_s=%h exp=0", pos_w, pos_s);
    n_total++;
    step();
    if (pos_w === {6'd60, 6'd4} && pos_s === {6'd0, 6'd4}) n_pass++;
    else $display("FAIL rst_repress pos_w=%h pos_s=%h exp=f04/004", pos_w, pos_s);
    n_total++;
    repeat (12) begin
      step();
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL rst_after cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
    Bt_Inc = '0; Bt_Dec = '0;
    repeat (3) step();
  endtask

  task automatic test_random();
    repeat (400) begin
      for (int a = 0; a < NA; a++)
        if ($urandom_range(0, 11) == 0) begin
          Bt_Inc[a] = 1'($urandom_range(0, 1));
          Bt_Dec[a] = 1'($urandom_range(0, 1));
        end
      Clr = ($urandom_range(0, 59) == 0);
      step();
      if (got_w === exp_vec(0) && got_s === exp_vec(1)) n_pass++;
      else $display("FAIL random cyc=%0d got=%h/%h exp=%h/%h", cyc, got_w, got_s, exp_vec(0), exp_vec(1));
      n_total++;
    end
    Clr = 1'b0; Bt_Inc = '0; Bt_Dec = '0;
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold();
    test_wrap();
    test_clamp();
    test_conflict();
    test_clr_priority();
    test_reset_mid_repeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
